fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the opcode decoder.
- Holds the PC and requests words from instruction memory over a req/ready handshake.
- Registers the fetched instruction, PC+4 and a valid bit; presents instr[31:26] as the opcode to the decoder.
- Supports stall from the hazard unit, with a one-entry skid buffer, and taken-branch redirect with flush.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, word written into IF/ID on flush or reset (sll $0,$0,0).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_addr  out  32  fetch address (= pc)
imem_req  out  1  fetch request
imem_ready  in  1  memory returns imem_rdata for imem_addr this cycle
imem_rdata  in  32  instruction word
stall  in  1  hazard unit: hold IF/ID contents
branch_taken  in  1  redirect PC and flush IF/ID
branch_target  in  32  redirect address
if_id_instr  out  32  registered instruction
if_id_pc4  out  32  registered PC+4 of that instruction
if_id_valid  out  1  IF/ID holds a real instruction
opcode  out  6  if_id_instr[31:26]; feeds the decoder

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0: pc=RESET_PC, state=START, if_id_instr=NOP_INSTR, if_id_pc4=0, if_id_valid=0, skid buffer cleared, imem_req=0.
- Deassertion is taken at the next clk edge.
- imem_req is registered from the state: 1 only in RUN. imem_addr=pc at all times.
- States:
  - START: req=0; next cycle goes to RUN unconditionally, unless branch_taken.
  - RUN: request outstanding at pc.
  - BUF: a fetched word sits in the skid buffer while the stage is stalled; req=0.
- Priority on each edge: branch_taken > stall > normal fetch.
- branch_taken=1 (any state):
  - pc<=branch_target.
  - IF/ID<=NOP_INSTR, pc4 0, valid 0.
  - Skid buffer discarded; state<=RUN.
  - Any imem_rdata returned this cycle is dropped.
  - Takes effect even if stall=1.
- RUN, imem_ready=1, stall=0: IF/ID<=rdata, pc4<=pc+4, valid<=1; pc<=pc+4. Sustained throughput is 1 instruction/cycle when ready is held high.
- RUN, imem_ready=1, stall=1: skid<=rdata, skid_pc4<=pc+4; pc<=pc+4; IF/ID unchanged; state<=BUF.
- RUN, imem_ready=0, stall=0: IF/ID valid<=0 (bubble inserted); pc and req held.
- RUN, imem_ready=0, stall=1: IF/ID fully held; pc and req held.
- BUF, stall=1: everything held.
- BUF, stall=0: IF/ID<=skid, valid<=1; state<=RUN, so req rises next cycle. There is no fetch this cycle and imem_ready is ignored in BUF.
- PC arithmetic: 32-bit, wraps 32'hFFFF_FFFC+4 -> 0. Low 2 bits are never forced; a misaligned target propagates as given.
- imem_addr is stable while req=1 and ready=0, except on branch_taken. Memory must accept an abandoned request.
- opcode is a pure combinational slice of if_id_instr. Latency from pc to opcode is 1 cycle when ready=1.

Decomposition:
- Shared package mips_pkg:
  - fetch state enum {START, RUN, BUF}
  - NOP_INSTR constant
  - opcode localparams (OP_RTYPE=0, OP_BEQ=4, OP_ADDI=8, OP_LUI=15, OP_LW=35, OP_SW=43), shared with the decoder
- One natural sub-module: if_id_reg. Holds instr, pc4 and valid, with load, hold and flush controls. Used here and reused for later pipeline registers.
- PC register, skid buffer and FSM stay in fetch_unit.

Test Plan:
- Reset, then ready=1 every cycle, rdata=addr-dependent pattern -> req rises 1 cycle after reset release. Addresses 0,4,8,... IF/ID shows word@0 with pc4=4 the next cycle, valid=1, opcode=rdata[31:26].
- ready=1, stall=1 for 3 cycles while fetching addr 0x8 (word 0x8C220004) -> state BUF, pc=0xC, req=0, IF/ID unchanged. On stall release IF/ID=0x8C220004, pc4=0xC, opcode=35. Fetch of 0xC follows 1 cycle later.
- ready=0 for 2 cycles at pc=0x10 -> addr held 0x10, if_id_valid=0 for both cycles. IF/ID loads when ready=1.
- branch_taken=1, target=0x40, same cycle as ready=1, stall=1 -> IF/ID=NOP, valid=0, skid discarded, next imem_addr=0x40, state RUN.
- Async reset asserted mid-BUF -> all outputs reach their reset values immediately, without waiting for a clk edge. After release: START, then RUN, fetch at RESET_PC.
- pc=0xFFFF_FFFC, ready=1 -> if_id_pc4=0, next imem_addr=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch FSM states, NOP word and the
// opcode values the decoder keys on.
package mips_pkg;

    typedef enum logic [1:0] {
        START = 2'd0,
        RUN   = 2'd1,
        BUF   = 2'd2
    } fetch_state_e;

    // sll $0,$0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between fetch and imem.
interface fetch_unit_if;
    logic [31:0] addr;
    logic        req;
    logic        ready;
    logic [31:0] rdata;

    modport master (output addr, output req, input ready, input rdata);
    modport slave  (input addr, input req, output ready, output rdata);
endinterface

// File: rtl/if_id_reg.sv
// Generic pipeline register holding instr/pc4/valid with flush, load and
// bubble (valid-only clear) controls; flush wins over load over bubble.
module if_id_reg #(
    parameter logic [31:0] FLUSH_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        load_i,
    input  logic        bubble_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc4_o,
    output logic        valid_o
);

    logic [31:0] instr_q;
    logic [31:0] pc4_q;
    logic        valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= FLUSH_INSTR;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            instr_q <= FLUSH_INSTR;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc4_q   <= pc4_i;
            valid_q <= 1'b1;
        end else if (bubble_i) begin
            valid_q <= 1'b0;
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, request FSM, one-entry skid buffer for words
// that land while the hazard unit stalls, and the IF/ID register.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_unit_if.master        imem,
    input  logic                stall_i,
    input  logic                branch_taken_i,
    input  logic [31:0]         branch_target_i,
    output logic [31:0]         if_id_instr_o,
    output logic [31:0]         if_id_pc4_o,
    output logic                if_id_valid_o,
    output logic [5:0]          opcode_o
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  skid_q;
    logic [31:0]  skid_pc4_q;
    logic         req_q;
    logic [31:0]  pc4_d;

    assign pc4_d = pc_plus4(pc_q);

    // req is registered from the next state so it is high exactly in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= START;
            pc_q       <= RESET_PC;
            skid_q     <= 32'd0;
            skid_pc4_q <= 32'd0;
            req_q      <= 1'b0;
        end else if (branch_taken_i) begin
            state_q    <= RUN;
            pc_q       <= branch_target_i;
            skid_q     <= 32'd0;
            skid_pc4_q <= 32'd0;
            req_q      <= 1'b1;
        end else begin
            case (state_q)
                START: begin
                    state_q <= RUN;
                    req_q   <= 1'b1;
                end
                RUN: begin
                    if (imem.ready) begin
                        pc_q <= pc4_d;
                        if (stall_i) begin
                            skid_q     <= imem.rdata;
                            skid_pc4_q <= pc4_d;
                            state_q    <= BUF;
                            req_q      <= 1'b0;
                        end
                    end
                end
                BUF: begin
                    if (!stall_i) begin
                        state_q <= RUN;
                        req_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= START;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    logic        ifid_load;
    logic        ifid_bubble;
    logic [31:0] ifid_instr_d;
    logic [31:0] ifid_pc4_d;

    always_comb begin
        ifid_load    = 1'b0;
        ifid_bubble  = 1'b0;
        ifid_instr_d = imem.rdata;
        ifid_pc4_d   = pc4_d;
        if (!branch_taken_i && !stall_i) begin
            if (state_q == RUN) begin
                ifid_load   = imem.ready;
                ifid_bubble = !imem.ready;
            end else if (state_q == BUF) begin
                // Drain the skid; memory is idle this cycle.
                ifid_load    = 1'b1;
                ifid_instr_d = skid_q;
                ifid_pc4_d   = skid_pc4_q;
            end
        end
    end

    if_id_reg #(.FLUSH_INSTR(NOP_INSTR)) u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (branch_taken_i),
        .load_i   (ifid_load),
        .bubble_i (ifid_bubble),
        .instr_i  (ifid_instr_d),
        .pc4_i    (ifid_pc4_d),
        .instr_o  (if_id_instr_o),
        .pc4_o    (if_id_pc4_o),
        .valid_o  (if_id_valid_o)
    );

    assign imem.addr = pc_q;
    assign imem.req  = req_q;
    assign opcode_o  = if_id_instr_o[31:26];

endmodule
